// File: rtl/inv_key_sched_if.sv
// Handshake and key bus between the key-load side, the inverse key
// schedule and the inverse round pipeline.
interface inv_key_sched_if;
  logic         start;
  logic [127:0] key_in;
  logic         out_ready;
  logic         out_valid;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         busy;
  logic         done;

  modport master (
    output start, key_in, out_ready,
    input  out_valid, round_key, round_num, busy, done
  );

  modport slave (
    input  start, key_in, out_ready,
    output out_valid, round_key, round_num, busy, done
  );
endinterface

// File: rtl/inv_key_sched.sv
// AES-128 inverse key schedule: loads the round-10 key and steps the
// expansion backwards one round per accepted key, emitting keys 10..0.
module inv_key_sched #(
  parameter int NR = 10
) (
  input  logic            clk,
  input  logic            rst,
  inv_key_sched_if.slave  ks
);

  // Forward AES S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    // ~x selects byte (255-x) counted from the bottom of the table
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  // Rcon is indexed by the round of the key being walked back from.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state, state_n;
  logic [127:0]  key_q, key_prev;
  logic [3:0]    num_q;
  logic          done_q;
  logic          accept;
  logic [31:0]   wa, wb, wc, wd;
  logic [31:0]   w0, w1, w2, w3;
  logic [31:0]   rot, sub;

  assign accept = (state == RUN) && ks.out_ready;

  // prev(): undo one round of expansion. The last three words fall out of
  // adjacent XORs; the first needs the g() function of the new last word.
  assign wa  = key_q[127:96];
  assign wb  = key_q[95:64];
  assign wc  = key_q[63:32];
  assign wd  = key_q[31:0];
  assign w3  = wd ^ wc;
  assign w2  = wc ^ wb;
  assign w1  = wb ^ wa;
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sub
    assign sub[8*i +: 8] = sbox(rot[8*i +: 8]);
  end

  assign w0       = wa ^ sub ^ {rcon(num_q), 24'h0};
  assign key_prev = {w0, w1, w2, w3};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state: leave IDLE on start, return once key 0 is accepted.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (ks.start) state_n = RUN;
      RUN:     if (ks.out_ready && num_q == 4'd0) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs: a key is presented for the whole of RUN.
  always_comb begin
    ks.out_valid = (state == RUN);
    ks.busy      = (state == RUN);
    ks.round_key = key_q;
    ks.round_num = num_q;
    ks.done      = done_q;
  end

  // Key/round registers: load on start, step back on each accepted key
  // except the last, which is left holding its value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q <= '0;
      num_q <= '0;
    end else if (state == IDLE && ks.start) begin
      key_q <= ks.key_in;
      num_q <= 4'(NR);
    end else if (accept && num_q != 4'd0) begin
      key_q <= key_prev;
      num_q <= num_q - 4'd1;
    end
  end

  // One-cycle done pulse in the first IDLE cycle after round 0 is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) done_q <= 1'b0;
    else     done_q <= accept && (num_q == 4'd0);
  end

endmodule

// File: doc/inv_key_sched.md
Name: inv_key_sched

Overview:
- Iterative AES-128 inverse key schedule for the decryption datapath.
- Takes the final round key (round 10) and walks the expansion backwards, emitting round keys 10, 9, …, 0 in the order the inverse cipher consumes them.
- Emits one key per accepted handshake. No stored key table is needed.
- Sits between the key-load interface and the inverse round pipeline. It uses the same RotWord, Rcon and SubWord primitives as the forward schedule, run in the opposite direction.

Parameters:
- NR, 10, number of rounds. Fixed for AES-128; only 10 is supported.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  load key_in and begin the walk; sampled only in IDLE
- key_in  input  128  round-10 key, w[40..43], w[40] in bits [127:96]
- out_ready  input  1  consumer accepts the current round_key
- out_valid  output  1  round_key/round_num hold a valid key
- round_key  output  128  current round key, w[4r..4r+3], w[4r] in [127:96]
- round_num  output  4  r of the current key, 10 down to 0
- busy  output  1  walk in progress
- done  output  1  one-cycle pulse after round 0 is accepted

Behaviour:
- Reset (async, immediate):
  - out_valid=0, round_key=0, round_num=0, busy=0, done=0.
  - State returns to IDLE. Any walk in progress is abandoned.
- States:
  - IDLE:
    - start=1 → next edge: round_key=key_in, round_num=10, out_valid=1, busy=1, go to RUN.
    - start=0 → stay in IDLE.
    - done is 1 only in the first IDLE cycle after a completed walk.
  - RUN, out_valid&&out_ready, round_num>0 → next edge: round_key=prev(round_key), round_num−1.
  - RUN, out_valid&&out_ready, round_num==0 → next edge: out_valid=0, busy=0, done=1, go to IDLE. round_key and round_num hold their last values.
  - RUN, out_ready=0 → round_key, round_num and out_valid hold stable.
- start is ignored while busy.
- start during the done cycle (IDLE) is accepted normally, so back-to-back walks are allowed.
- prev() for current key words a,b,c,d = w[4r..4r+3], r = round_num:
  - w[4r−1] = d^c
  - w[4r−2] = c^b
  - w[4r−3] = b^a
  - w[4r−4] = a ^ SubWord(RotWord(w[4r−1])) ^ {Rcon[r],24'h0}
- RotWord is a left byte rotate: {b0,b1,b2,b3}→{b1,b2,b3,b0}.
- SubWord applies the forward S-box to each of the four bytes (forward, not inverse, box).
- Rcon[r] for r=1..10: 01,02,04,08,10,20,40,80,1b,36. It is indexed by the current round_num; the r=0 entry is unused.
- All arithmetic is GF(2) XOR, 32-bit words, with no carries.
- prev() is a single combinational stage feeding registered outputs. Throughput is one key per cycle when out_ready is held high.
- Walk latency: 11 keys over 11 valid cycles minimum, plus 1 done cycle.

Test Plan:
- FIPS-197 vector, out_ready=1:
  - Stimulus: start with key_in=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Required response: out_valid for 11 consecutive cycles.
  - round_num=10 key equals key_in.
  - round_num=9 key = ac7766f319fadc2128d12941575c006e.
  - round_num=1 key = a0fafe1788542cb123a339392a6c7605.
  - round_num=0 key = 2b7e151628aed2a6abf7158809cf4f3c.
  - done=1 for exactly one cycle afterwards; busy falls in the same cycle.
- Backpressure:
  - Stimulus: same vector, drop out_ready for 3 cycles while round_num=9.
  - Required response: round_key stays ac7766f3… and round_num stays 9 throughout; the sequence resumes correctly; total valid cycles = 14.
- Start while busy:
  - Stimulus: pulse start with key_in=0 at round_num=6.
  - Required response: no effect; remaining keys match the FIPS sequence.
- Async reset mid-walk:
  - Stimulus: assert rst between clock edges at round_num=5.
  - Required response: all outputs go 0 before the next edge; after release, a fresh start walks the full 11 keys correctly.
- Randomised cross-check:
  - Stimulus: for 100 random cipher keys, expand forward in the bench model and feed the round-10 key.
  - Required response: all 11 emitted keys match the model in reverse order, with random out_ready stalls.
- Back-to-back:
  - Stimulus: assert start in the done cycle.
  - Required response: a new walk begins on the next edge with round_num=10 and done=0.
